muldiv_alu: RTL and testbench
=============================

MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of two, 8..64).
REQ-002 SHALL have parameter OPW, default 6, ALUControl width.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port InValid  input  1  operation request.
REQ-006 SHALL have port InReady  output  1  block can accept a request.
REQ-007 SHALL have port ALUControl  input  OPW  operation select.
REQ-008 SHALL have ports A, B  input  WIDTH  operands.
REQ-009 SHALL have port ShiftAmount  input  log2(WIDTH)  immediate shift count.
REQ-010 SHALL have port OutValid  output  1  result available.
REQ-011 SHALL have port OutReady  input  1  consumer accepts result.
REQ-012 SHALL have port ALUResult  output  WIDTH  registered result.
REQ-013 SHALL have ports Zero, Overflow, DivZero  output  1  each  status flags, valid with OutValid.
REQ-014 SHALL have ports Hi, Lo  output  WIDTH  architectural HI/LO registers, always visible.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-016 SHALL drive InReady=1 only in IDLE; accept when InValid&&InReady.
REQ-017 SHALL register operands and control on acceptance; input changes after acceptance have no effect.
REQ-018 Single-cycle ops (codes 0x00-0x1B, team ALU op table; 0x1E MFHI -> Hi; 0x1F MFLO -> Lo) SHALL go IDLE->DONE, OutValid one cycle after acceptance.
REQ-019 MULT 0x02, MULTU 0x0D, MADD 0x20, MSUB 0x21 SHALL go IDLE->MUL, iterate WIDTH cycles (shift-add), then DONE: latency WIDTH+1.
REQ-020 DIV 0x1C, DIVU 0x1D SHALL go IDLE->DIV, WIDTH restoring iterations, then DONE: latency WIDTH+1.
REQ-021 MULT/MULTU SHALL write {Hi,Lo}=full 2*WIDTH product; ALUResult=low half.
REQ-022 MADD/MSUB SHALL write {Hi,Lo} = {Hi,Lo} +/- signed A*B, modulo 2^(2*WIDTH).
REQ-023 DIV SHALL truncate toward zero; Lo=quotient, Hi=remainder with dividend sign; ALUResult=quotient.
REQ-024 Divide by zero SHALL still take WIDTH+1 cycles; Lo=all ones, Hi=A, DivZero=1.
REQ-025 DIV of most-negative by -1 SHALL give Lo=most-negative, Hi=0, Overflow=1.
REQ-026 ADD/SUB (signed) SHALL set Overflow on two's-complement overflow; all other ops Overflow=0.
REQ-027 Move 0x15 SHALL write Hi=Lo=A, ALUResult=A.
REQ-028 Undefined codes SHALL complete single-cycle with ALUResult=1, Hi/Lo unchanged.
REQ-029 Zero SHALL equal (ALUResult==0), registered with result.
REQ-030 In DONE SHALL hold OutValid and all outputs stable until OutReady; OutValid&&OutReady -> IDLE next cycle.
REQ-031 Hi/Lo SHALL update exactly on the MUL/DIV->DONE transition (or the DONE entry for move); single-cycle ops read Hi/Lo as of acceptance.
REQ-032 Shifts/rotates SHALL use count modulo WIDTH; variable forms use A[log2(WIDTH)-1:0].

Reset
REQ-033 Rst low SHALL asynchronously force IDLE, iteration counter 0, Hi=Lo=0, ALUResult=0, OutValid=0, all flags 0; InReady=1 after release.
REQ-034 Reset during MUL/DIV SHALL abort the operation with no partial Hi/Lo update.

Structure
REQ-035 Op codes, FSM state encoding, and WIDTH-derived constants SHALL live in shared package alu_pkg.
REQ-036 Iterative datapath SHALL be sub-module muldiv_iter (start, signed/op inputs, counter, done pulse, 2*WIDTH result).

Verification
REQ-037 ADD A=0x7FFFFFFF,B=1 -> ALUResult=0x80000000, Overflow=1, OutValid at cycle 1.
REQ-038 MULT A=0xFFFFFFFE(-2),B=3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, OutValid exactly 33 cycles after acceptance.
REQ-039 DIV A=-7,B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=7,B=0 -> Lo=0xFFFFFFFF, Hi=7, DivZero=1.
REQ-040 MADD with Hi=0,Lo=0xFFFFFFFF, A=1,B=1 -> Hi=1, Lo=0; then MFHI -> ALUResult=1.
REQ-041 OutReady held low 5 cycles after result -> outputs stable, InReady=0, new InValid ignored.
REQ-042 Rst asserted at cycle 10 of DIV -> immediate IDLE, Hi=Lo=0, OutValid=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM encoding and width helpers shared by muldiv_alu
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_OPW   = 6;
  localparam int OPC_W     = 8;

  localparam logic [OPC_W-1:0] OP_AND   = 8'h00;
  localparam logic [OPC_W-1:0] OP_OR    = 8'h01;
  localparam logic [OPC_W-1:0] OP_MULT  = 8'h02;
  localparam logic [OPC_W-1:0] OP_ADD   = 8'h03;
  localparam logic [OPC_W-1:0] OP_ADDU  = 8'h04;
  localparam logic [OPC_W-1:0] OP_SUB   = 8'h05;
  localparam logic [OPC_W-1:0] OP_SUBU  = 8'h06;
  localparam logic [OPC_W-1:0] OP_XOR   = 8'h07;
  localparam logic [OPC_W-1:0] OP_NOR   = 8'h08;
  localparam logic [OPC_W-1:0] OP_SLT   = 8'h09;
  localparam logic [OPC_W-1:0] OP_SLTU  = 8'h0A;
  localparam logic [OPC_W-1:0] OP_SLL   = 8'h0B;
  localparam logic [OPC_W-1:0] OP_SRL   = 8'h0C;
  localparam logic [OPC_W-1:0] OP_MULTU = 8'h0D;
  localparam logic [OPC_W-1:0] OP_SRA   = 8'h0E;
  localparam logic [OPC_W-1:0] OP_SLLV  = 8'h0F;
  localparam logic [OPC_W-1:0] OP_SRLV  = 8'h10;
  localparam logic [OPC_W-1:0] OP_SRAV  = 8'h11;
  localparam logic [OPC_W-1:0] OP_ROTR  = 8'h12;
  localparam logic [OPC_W-1:0] OP_ROTRV = 8'h13;
  localparam logic [OPC_W-1:0] OP_ANDN  = 8'h14;
  localparam logic [OPC_W-1:0] OP_MOVE  = 8'h15;
  localparam logic [OPC_W-1:0] OP_SEQ   = 8'h16;
  localparam logic [OPC_W-1:0] OP_SNE   = 8'h17;
  localparam logic [OPC_W-1:0] OP_MIN   = 8'h18;
  localparam logic [OPC_W-1:0] OP_MAX   = 8'h19;
  localparam logic [OPC_W-1:0] OP_ORN   = 8'h1A;
  localparam logic [OPC_W-1:0] OP_XNOR  = 8'h1B;
  localparam logic [OPC_W-1:0] OP_DIV   = 8'h1C;
  localparam logic [OPC_W-1:0] OP_DIVU  = 8'h1D;
  localparam logic [OPC_W-1:0] OP_MFHI  = 8'h1E;
  localparam logic [OPC_W-1:0] OP_MFLO  = 8'h1F;
  localparam logic [OPC_W-1:0] OP_MADD  = 8'h20;
  localparam logic [OPC_W-1:0] OP_MSUB  = 8'h21;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Bits needed for a shift count, which doubles as the iteration counter width.
  function automatic int shamt_bits(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle shift-add multiplier / restoring divider
// Works on magnitudes; sign correction is applied on the final step's result.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               is_div_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = shamt_bits(WIDTH);

  logic               busy_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q, neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag;
  logic [WIDTH:0]     mul_sum, rem_diff;

  assign a_mag  = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag  = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  assign done_o = busy_q && (count_q == CW'(WIDTH-1));

  // work_q holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    rem_diff = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]} - {1'b0, opnd_q};
    if (is_div_q) begin
      if (rem_diff[WIDTH]) begin
        work_d = {work_q[2*WIDTH-2:WIDTH], work_q[WIDTH-1], work_q[WIDTH-2:0], 1'b0};
      end else begin
        work_d = {rem_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      work_d = {mul_sum, work_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    q_mag = work_d[WIDTH-1:0];
    r_mag = work_d[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      result_o = {(neg_hi_q ? -r_mag : r_mag), (neg_lo_q ? -q_mag : q_mag)};
    end else begin
      result_o = neg_lo_q ? -work_d : work_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= 1'b0;
      count_q  <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      count_q  <= '0;
      work_q   <= {{WIDTH{1'b0}}, (is_div_i ? a_mag : b_mag)};
      opnd_q   <= is_div_i ? b_mag : a_mag;
      is_div_q <= is_div_i;
      neg_lo_q <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      neg_hi_q <= signed_i && a_i[WIDTH-1];
    end else if (busy_q) begin
      work_q  <= work_d;
      count_q <= count_q + CW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/muldiv_alu.sv
// rtl/muldiv_alu.sv - single-cycle ALU with iterative MUL/DIV and HI/LO registers
// Results are held in DONE until the consumer accepts them.
module muldiv_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW,
  localparam int SW   = shamt_bits(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [OPW-1:0]   ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SW-1:0]    ShiftAmount,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d, lo_q, lo_d, a_q, a_d;
  logic               zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;
  logic               bz_q, bz_d, dovf_q, dovf_d;
  logic [OPC_W-1:0]   op_q, op_d, op_code;
  logic               is_mul_op, is_div_op, op_signed, start;
  logic               iter_done;
  logic [2*WIDTH-1:0] iter_res, hilo_new;
  logic [WIDTH-1:0]   alu_res, sum, diff;
  logic               alu_ovf;
  logic [2*WIDTH-1:0] rot_imm, rot_var;

  assign op_code   = OPC_W'(ALUControl);
  assign is_mul_op = (op_code == OP_MULT) || (op_code == OP_MULTU) ||
                     (op_code == OP_MADD) || (op_code == OP_MSUB);
  assign is_div_op = (op_code == OP_DIV) || (op_code == OP_DIVU);
  assign op_signed = !((op_code == OP_MULTU) || (op_code == OP_DIVU));

  assign InReady   = (state_q == S_IDLE);
  assign OutValid  = (state_q == S_DONE);
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign DivZero   = dz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk_i    (Clk),
    .rst_ni   (Rst),
    .start_i  (start),
    .is_div_i (is_div_op),
    .signed_i (op_signed),
    .a_i      (A),
    .b_i      (B),
    .done_o   (iter_done),
    .result_o (iter_res)
  );

  // Variable shifts take the count from A and shift B; rotates use a doubled word.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = A + B;
    diff    = A - B;
    rot_imm = {B, B} >> ShiftAmount;
    rot_var = {B, B} >> A[SW-1:0];
    case (op_code)
      OP_AND:   alu_res = A & B;
      OP_OR:    alu_res = A | B;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_ADDU:  alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUBU:  alu_res = diff;
      OP_XOR:   alu_res = A ^ B;
      OP_NOR:   alu_res = ~(A | B);
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:   alu_res = B << ShiftAmount;
      OP_SRL:   alu_res = B >> ShiftAmount;
      OP_SRA:   alu_res = $signed(B) >>> ShiftAmount;
      OP_SLLV:  alu_res = B << A[SW-1:0];
      OP_SRLV:  alu_res = B >> A[SW-1:0];
      OP_SRAV:  alu_res = $signed(B) >>> A[SW-1:0];
      OP_ROTR:  alu_res = rot_imm[WIDTH-1:0];
      OP_ROTRV: alu_res = rot_var[WIDTH-1:0];
      OP_ANDN:  alu_res = A & ~B;
      OP_MOVE:  alu_res = A;
      OP_SEQ:   alu_res = {{(WIDTH-1){1'b0}}, (A == B)};
      OP_SNE:   alu_res = {{(WIDTH-1){1'b0}}, (A != B)};
      OP_MIN:   alu_res = ($signed(A) < $signed(B)) ? A : B;
      OP_MAX:   alu_res = ($signed(A) < $signed(B)) ? B : A;
      OP_ORN:   alu_res = A | ~B;
      OP_XNOR:  alu_res = ~(A ^ B);
      OP_MFHI:  alu_res = hi_q;
      OP_MFLO:  alu_res = lo_q;
      default:  alu_res = WIDTH'(1);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op_d     = op_q;
    a_d      = a_q;
    bz_d     = bz_q;
    dovf_d   = dovf_q;
    start    = 1'b0;
    hilo_new = '0;
    case (state_q)
      S_IDLE: begin
        if (InValid) begin
          op_d   = op_code;
          a_d    = A;
          bz_d   = (B == '0);
          dovf_d = (op_code == OP_DIV) && (A == MOST_NEG) && (B == '1);
          if (is_mul_op) begin
            state_d = S_MUL;
            start   = 1'b1;
          end else if (is_div_op) begin
            state_d = S_DIV;
            start   = 1'b1;
          end else begin
            state_d = S_DONE;
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            ovf_d   = alu_ovf;
            dz_d    = 1'b0;
            if (op_code == OP_MOVE) begin
              hi_d = A;
              lo_d = A;
            end
          end
        end
      end
      S_MUL, S_DIV: begin
        // HI/LO are committed only here, so an aborted operation never leaves partial state.
        if (iter_done) begin
          state_d = S_DONE;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          case (op_q)
            OP_MADD: hilo_new = {hi_q, lo_q} + iter_res;
            OP_MSUB: hilo_new = {hi_q, lo_q} - iter_res;
            default: hilo_new = iter_res;
          endcase
          if (state_q == S_DIV) begin
            if (bz_q) begin
              hilo_new = {a_q, {WIDTH{1'b1}}};
              dz_d     = 1'b1;
            end
            ovf_d = dovf_q;
          end
          hi_d   = hilo_new[2*WIDTH-1:WIDTH];
          lo_d   = hilo_new[WIDTH-1:0];
          res_d  = hilo_new[WIDTH-1:0];
          zero_d = (hilo_new[WIDTH-1:0] == '0);
        end
      end
      S_DONE: begin
        if (OutReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      bz_q    <= 1'b0;
      dovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      bz_q    <= bz_d;
      dovf_q  <= dovf_d;
    end
  end

endmodule

// File: tb/tb_muldiv_alu.sv
// tb/tb_muldiv_alu.sv - scoreboard bench for muldiv_alu at WIDTH=32
module tb_muldiv_alu;
  import alu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        InValid = 1'b0;
  logic        OutReady = 1'b0;
  logic [5:0]  ALUControl = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0]  ShiftAmount = '0;
  logic        InReady, OutValid, Zero, Overflow, DivZero;
  logic [31:0] ALUResult, Hi, Lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    logic        dz;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] rnd_ops [0:15] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_SRA, OP_SRLV,
                                  OP_ROTR, OP_MIN, OP_MAX, OP_XNOR, OP_MULT, OP_MULTU,
                                  OP_DIV, OP_DIVU, OP_MADD, OP_MSUB};

  muldiv_alu dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .ALUControl(ALUControl), .A(A), .B(B), .ShiftAmount(ShiftAmount),
    .OutValid(OutValid), .OutReady(OutReady), .ALUResult(ALUResult),
    .Zero(Zero), .Overflow(Overflow), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sa);
    exp_t        e;
    longint      s, p;
    logic [63:0] acc;
    int          ia, ib;
    e.hi = m_hi; e.lo = m_lo; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1; e.res = 32'd1;
    p = longint'($signed(a)) * longint'($signed(b));
    case (op)
      OP_AND:   e.res = a & b;
      OP_ADD: begin
        s = longint'($signed(a)) + longint'($signed(b));
        e.res = a + b;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUB: begin
        s = longint'($signed(a)) - longint'($signed(b));
        e.res = a - b;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SLT:   e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:  e.res = (a < b) ? 32'd1 : 32'd0;
      OP_SRA:   e.res = $signed(b) >>> sa;
      OP_SRLV:  e.res = b >> a[4:0];
      OP_ROTR:  e.res = (b >> sa) | (b << (32 - sa));
      OP_ROTRV: e.res = (b >> a[4:0]) | (b << (32 - a[4:0]));
      OP_MIN:   e.res = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:   e.res = ($signed(a) > $signed(b)) ? a : b;
      OP_XNOR:  e.res = ~(a ^ b);
      OP_MOVE: begin e.res = a; e.hi = a; e.lo = a; end
      OP_MFHI:  e.res = m_hi;
      OP_MFLO:  e.res = m_lo;
      OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
        if (op == OP_MULTU) acc = {32'd0, a} * {32'd0, b};
        else if (op == OP_MULT) acc = 64'(p);
        else if (op == OP_MADD) acc = {m_hi, m_lo} + 64'(p);
        else acc = {m_hi, m_lo} - 64'(p);
        e.hi = acc[63:32]; e.lo = acc[31:0]; e.res = acc[31:0]; e.lat = 33;
      end
      OP_DIV, OP_DIVU: begin
        e.lat = 33;
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
        end else if (op == OP_DIVU) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'd0; e.ovf = 1'b1;
        end else begin
          ia = int'(a); ib = int'(b);
          e.lo = ia / ib; e.hi = ia % ib;
        end
        e.res = e.lo;
      end
      default:  e.res = 32'd1;
    endcase
    return e;
  endfunction

  task automatic do_op(input string name, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sa, input int stall);
    exp_t e;
    int   cyc;
    e = model(op, a, b, sa);
    m_hi = e.hi; m_lo = e.lo;
    sb_q.push_back(e);
    @(negedge Clk);
    chk({name, "_inready"}, 64'(InReady), 64'd1);
    InValid = 1'b1; ALUControl = op[5:0]; A = a; B = b; ShiftAmount = sa;
    @(posedge Clk); #1;
    InValid = 1'b0; A = $urandom; B = $urandom; ShiftAmount = 5'($urandom);
    ALUControl = 6'($urandom);
    cyc = 1;
    while (!OutValid && cyc < 100) begin
      @(posedge Clk); #1;
      cyc++;
    end
    e = sb_q.pop_front();
    chk({name, "_lat"}, 64'(cyc), 64'(e.lat));
    chk({name, "_res"}, 64'(ALUResult), 64'(e.res));
    chk({name, "_hi"}, 64'(Hi), 64'(e.hi));
    chk({name, "_lo"}, 64'(Lo), 64'(e.lo));
    chk({name, "_ovf"}, 64'(Overflow), 64'(e.ovf));
    chk({name, "_dz"}, 64'(DivZero), 64'(e.dz));
    chk({name, "_zero"}, 64'(Zero), 64'(e.res == 32'd0));
    for (int i = 0; i < stall; i++) begin
      @(negedge Clk);
      InValid = 1'b1; ALUControl = OP_ADD[5:0]; A = $urandom; B = $urandom;
      @(posedge Clk); #1;
      chk({name, "_stall_valid"}, 64'(OutValid), 64'd1);
      chk({name, "_stall_inready"}, 64'(InReady), 64'd0);
      chk({name, "_stall_res"}, 64'(ALUResult), 64'(e.res));
      chk({name, "_stall_hilo"}, {Hi, Lo}, {e.hi, e.lo});
    end
    InValid = 1'b0; OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    chk({name, "_release"}, {62'd0, OutValid, InReady}, 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_outvalid", 64'(OutValid), 64'd0);
    chk("reset_result", 64'(ALUResult), 64'd0);
    chk("reset_hilo", {Hi, Lo}, 64'd0);
    chk("reset_flags", {61'd0, Zero, Overflow, DivZero}, 64'd0);
    @(negedge Clk); Rst = 1'b1;
    @(posedge Clk); #1;
    chk("reset_inready", 64'(InReady), 64'd1);

    do_op("add_ovf",   OP_ADD,   32'h7FFF_FFFF, 32'd1,         5'd0, 0);
    do_op("sub_ovf",   OP_SUB,   32'h8000_0000, 32'd1,         5'd0, 0);
    do_op("and_zero",  OP_AND,   32'h0000_0F0F, 32'h0000_F0F0, 5'd0, 0);
    do_op("slt",       OP_SLT,   32'hFFFF_FFFF, 32'd1,         5'd0, 0);
    do_op("sra",       OP_SRA,   32'd0,         32'h8000_0000, 5'd4, 0);
    do_op("rotrv",     OP_ROTRV, 32'd40,        32'h1234_5678, 5'd0, 0);
    do_op("mult",      OP_MULT,  32'hFFFF_FFFE, 32'd3,         5'd0, 0);
    do_op("multu",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0);
    do_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         5'd0, 0);
    do_op("div_negb",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 5'd0, 0);
    do_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
    do_op("divu_zero", OP_DIVU,  32'd7,         32'd0,         5'd0, 0);
    do_op("multu_ld",  OP_MULTU, 32'hFFFF_FFFF, 32'd1,         5'd0, 0);
    do_op("madd",      OP_MADD,  32'd1,         32'd1,         5'd0, 0);
    do_op("mfhi_stall", OP_MFHI, 32'd0,         32'd0,         5'd0, 5);
    do_op("msub",      OP_MSUB,  32'd3,         32'd4,         5'd0, 0);
    do_op("move",      OP_MOVE,  32'hDEAD_BEEF, 32'd5,         5'd0, 0);
    do_op("undef",     8'h30,    32'h1234_0000, 32'd9,         5'd0, 0);
    do_op("mflo",      OP_MFLO,  32'd0,         32'd0,         5'd0, 0);

    for (int i = 0; i < 16; i++) begin
      logic [7:0] op;
      op = rnd_ops[$urandom_range(0, 15)];
      do_op($sformatf("rnd%0d", i), op, $urandom, $urandom, 5'($urandom), 0);
    end

    do_op("move_pre", OP_MOVE, 32'hCAFE_F00D, 32'd0, 5'd0, 0);
    @(negedge Clk);
    InValid = 1'b1; ALUControl = OP_DIV[5:0]; A = 32'd100; B = 32'd7;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (9) @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("abort_outvalid", 64'(OutValid), 64'd0);
    chk("abort_hilo", {Hi, Lo}, 64'd0);
    chk("abort_result", 64'(ALUResult), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge Clk); Rst = 1'b1;
    @(posedge Clk); #1;
    chk("abort_inready", 64'(InReady), 64'd1);
    chk("abort_idle", 64'(OutValid), 64'd0);
    do_op("mfhi_post", OP_MFHI, 32'd0, 32'd0, 5'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
